aes_xram_sequencer: RTL and testbench
=====================================

AES_XRAM_SEQUENCER -- requirements
Module: aes_xram_sequencer

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL have cfg_start input 1: start-operation pulse, sampled in IDLE only.
REQ-003 SHALL have cfg_opaddr input 16: XRAM base byte address.
REQ-004 SHALL have cfg_oplen input 16: operation length in bytes, bits [3:0] ignored.
REQ-005 SHALL have cfg_ctr input 128: initial counter block.
REQ-006 SHALL have busy output 1 (high when state != IDLE), and done output 1 (one-cycle completion pulse).
REQ-007 SHALL have uaes_ctr output 128: current counter register.
REQ-008 SHALL have the XRAM port xram_addr output 16, xram_data_out output 8, stb output 1 (request strobe), wr output 1 (1=write), xram_ack input 1, xram_data_in input 8.
REQ-009 SHALL have the cipher port aes_start output 1 (one-cycle pulse), aes_ctr_out output 128, aes_done input 1, aes_out input 128 (keystream).

Function
REQ-010 SHALL use states IDLE, READ, OPERATE, WRITE, DONE.
REQ-011 IDLE: on cfg_start=1, SHALL latch opaddr, nblk = cfg_oplen[15:4], and uaes_ctr <= cfg_ctr.
- nblk==0: next state DONE.
- otherwise: next state READ.
REQ-012 READ SHALL issue 16 byte reads at addresses opaddr + 16*blk + i, i = 0..15, with 16-bit wrap-around (FFFF -> 0000).
- Byte i captured into buf[127-8i -: 8] in the cycle xram_ack=1.
REQ-013 XRAM handshake:
- stb, wr and xram_addr (plus xram_data_out on writes) held stable from assertion until the cycle xram_ack=1.
- stb deasserts the cycle after ack.
- Next request no earlier than the cycle after stb deasserts.
- xram_ack while stb=0 SHALL be ignored.
REQ-014 After the 16th read ack, SHALL enter OPERATE.
- aes_start pulses for exactly one cycle with aes_ctr_out = uaes_ctr.
- SHALL wait for aes_done=1, capturing aes_out that cycle.
- aes_done arriving in the same cycle as aes_start SHALL be accepted.
REQ-015 WRITE SHALL issue 16 byte writes to the same addresses as the preceding READ, with xram_data_out = buf byte i XOR aes_out[127-8i -: 8].
REQ-016 After the 16th write ack:
- uaes_ctr <= uaes_ctr + 1, modulo 2^128.
- blk increments.
- Next state READ if blk+1 < nblk, else DONE.
REQ-017 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-018 cfg_start outside IDLE SHALL be ignored.
REQ-019 Throughput with zero-wait ack: each byte transfer costs 2 cycles (stb cycle with ack, then idle gap).

Reset
REQ-020 On rst=1, the state SHALL go to IDLE on the next edge.
- Reset values: busy=0, done=0, stb=0, wr=0, aes_start=0, xram_addr=0, xram_data_out=0, aes_ctr_out=0, uaes_ctr=0; internal buf and counters = 0.
REQ-021 Reset mid-operation SHALL abandon any outstanding XRAM or cipher transaction without completing it; a late xram_ack or aes_done after reset SHALL be ignored.

Configuration
REQ-022 With AES_SEQ_ABORT_EN defined, the block SHALL add input cfg_abort (1) and output aborted (1).
- cfg_abort=1 in READ/WRITE: finish the outstanding XRAM transaction (wait for ack if stb=1), then go to IDLE.
- cfg_abort=1 in OPERATE: go to IDLE immediately.
- In all abort cases: aborted pulses one cycle on return to IDLE, done is not asserted, uaes_ctr holds its value.
- cfg_abort in IDLE/DONE SHALL be ignored.
REQ-023 Without AES_SEQ_ABORT_EN, cfg_abort and aborted SHALL be absent and operations always run to completion.

Verification
REQ-024 cfg_oplen=0x0000 start -> busy 1 cycle, done pulse, zero stb, uaes_ctr=cfg_ctr.
REQ-025 opaddr=0x0100, oplen=0x0010, ctr=0x...05, zero-wait ack, aes_out=all 0xFF, data 0x00..0x0F -> 16 reads then 16 writes to 0x0100..0x010F with data 0xFF..0xF0, uaes_ctr=0x...06, done once.
REQ-026 opaddr=0xFFF8, oplen=0x0020 -> addresses wrap 0xFFF8..0xFFFF, 0x0000..0x0017; two aes_start pulses with ctr C then C+1.
REQ-027 ctr=2^128-1, oplen=0x0010 -> uaes_ctr wraps to 0 after block.
REQ-028 xram_ack delayed 3 cycles per request, cfg_start re-pulsed mid-op -> stb/addr stable until ack, second start ignored.
REQ-029 With AES_SEQ_ABORT_EN, abort during OPERATE of block 0 -> IDLE next cycle, aborted pulse, no writes, done never high; rst mid-WRITE -> IDLE, stb=0 next cycle.

Source files
------------

// File: rtl/aes_xram_sequencer_if.sv
// -----------------------------------------------------------------------------
// aes_xram_sequencer_if
//
// Purpose:
//   Groups the two bus ports of the AES-CTR XRAM sequencer. The XRAM side is a
//   byte-wide strobe/ack request port. The cipher side is a start/done
//   handshake that returns one 128-bit keystream block.
//
// Signals:
//   xram_addr      [15:0]  byte address of the current request
//   xram_data_out  [7:0]   write data (meaningful when wr=1)
//   stb                    request strobe, held until xram_ack
//   wr                     1 = write, 0 = read
//   xram_ack               request accepted/completed this cycle
//   xram_data_in   [7:0]   read data, valid with xram_ack on reads
//   aes_start              one-cycle cipher start pulse
//   aes_ctr_out    [127:0] counter block presented to the cipher
//   aes_done               cipher result valid this cycle
//   aes_out        [127:0] keystream block
//
// Modports:
//   master - the sequencer (drives requests and aes_start)
//   slave  - the memory / cipher side (drives acks, read data and aes_out)
// -----------------------------------------------------------------------------
interface aes_xram_sequencer_if;
    logic [15:0]  xram_addr;
    logic [7:0]   xram_data_out;
    logic         stb;
    logic         wr;
    logic         xram_ack;
    logic [7:0]   xram_data_in;
    logic         aes_start;
    logic [127:0] aes_ctr_out;
    logic         aes_done;
    logic [127:0] aes_out;

    modport master (
        output xram_addr, xram_data_out, stb, wr, aes_start, aes_ctr_out,
        input  xram_ack, xram_data_in, aes_done, aes_out
    );

    modport slave (
        input  xram_addr, xram_data_out, stb, wr, aes_start, aes_ctr_out,
        output xram_ack, xram_data_in, aes_done, aes_out
    );
endinterface

// File: rtl/aes_xram_sequencer.sv
// -----------------------------------------------------------------------------
// aes_xram_sequencer
//
// Purpose:
//   AES-CTR sequencer over a byte-wide XRAM. For each 16-byte block it reads
//   the block from XRAM, asks the cipher for one keystream block using the
//   current counter, writes back data XOR keystream to the same addresses and
//   increments the counter. Addresses wrap at 16 bits.
//
// Optional feature:
//   `define AES_SEQ_ABORT_EN adds cfg_abort / aborted. Without it every started
//   operation runs to completion.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   cfg_start             start pulse, only looked at in IDLE
//   cfg_opaddr [15:0]     XRAM base byte address
//   cfg_oplen  [15:0]     length in bytes; bits [3:0] are ignored
//   cfg_ctr    [127:0]    initial counter block
//   cfg_abort             (AES_SEQ_ABORT_EN) abort request
//   aborted               (AES_SEQ_ABORT_EN) one-cycle pulse on abort return
//   busy                  high whenever the FSM is not in IDLE
//   done                  one-cycle completion pulse
//   uaes_ctr   [127:0]    current counter register
//   bus                   XRAM + cipher ports (aes_xram_sequencer_if.master)
// -----------------------------------------------------------------------------
module aes_xram_sequencer (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_start,
    input  logic [15:0]                 cfg_opaddr,
    input  logic [15:0]                 cfg_oplen,
    input  logic [127:0]                cfg_ctr,
`ifdef AES_SEQ_ABORT_EN
    input  logic                        cfg_abort,
    output logic                        aborted,
`endif
    output logic                        busy,
    output logic                        done,
    output logic [127:0]                uaes_ctr,
    aes_xram_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        OPERATE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t       state, state_next;
    logic [15:0]  opaddr;
    logic [11:0]  nblk;
    logic [11:0]  blk;
    logic [3:0]   idx;          // byte index within the current block
    logic [127:0] buf_q;        // plaintext/ciphertext block read from XRAM
    logic [127:0] ks;           // keystream captured from the cipher
    logic         abort_in;
    logic         abort_pend;   // abort seen while a request was still open
    logic         abort_req;
    logic         xfer_ack;
    logic         last_byte;
    logic         issue;
    logic         abort_now;
    logic [6:0]   byte_lsb;

`ifdef AES_SEQ_ABORT_EN
    assign abort_in = cfg_abort;
`else
    assign abort_in = 1'b0;
`endif

    assign abort_req = abort_in | abort_pend;
    // An ack only counts while our strobe is up; stray acks are ignored.
    assign xfer_ack  = bus.stb & bus.xram_ack;
    assign last_byte = (idx == 4'd15);
    // Byte i lives at bits [127-8i -: 8], i.e. its LSB is 8*(15-i).
    assign byte_lsb  = {~idx, 3'b000};
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        abort_now  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start)
                    state_next = (cfg_oplen[15:4] == 12'd0) ? DONE : READ;
            end
            READ, WRITE: begin
                if (abort_req && (!bus.stb || bus.xram_ack)) begin
                    // Nothing outstanding (or it completes now): leave.
                    state_next = IDLE;
                    abort_now  = 1'b1;
                end else if (xfer_ack && last_byte) begin
                    if (state == READ)                state_next = OPERATE;
                    else if ((blk + 12'd1) < nblk)    state_next = READ;
                    else                              state_next = DONE;
                end else if (!bus.stb) begin
                    // The cycle after an ack is the mandatory gap, so a new
                    // request is only raised from a strobe-low cycle.
                    issue = 1'b1;
                end
            end
            OPERATE: begin
                if (abort_in) begin
                    state_next = IDLE;
                    abort_now  = 1'b1;
                end else if (bus.aes_done) begin
                    state_next = WRITE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data block and keystream registers are reset too, so a
            // reset always leaves the datapath in a known, all-zero state.
            opaddr            <= '0;
            nblk              <= '0;
            blk               <= '0;
            idx               <= '0;
            buf_q             <= '0;
            ks                <= '0;
            uaes_ctr          <= '0;
            abort_pend        <= 1'b0;
            bus.stb           <= 1'b0;
            bus.wr            <= 1'b0;
            bus.xram_addr     <= '0;
            bus.xram_data_out <= '0;
            bus.aes_start     <= 1'b0;
            bus.aes_ctr_out   <= '0;
`ifdef AES_SEQ_ABORT_EN
            aborted           <= 1'b0;
`endif
        end else begin
            bus.aes_start <= 1'b0;
            abort_pend    <= 1'b0;
`ifdef AES_SEQ_ABORT_EN
            aborted       <= abort_now;
`endif
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        opaddr   <= cfg_opaddr;
                        nblk     <= cfg_oplen[15:4];
                        uaes_ctr <= cfg_ctr;
                        blk      <= '0;
                        idx      <= '0;
                    end
                end
                READ, WRITE: begin
                    if (issue) begin
                        bus.stb       <= 1'b1;
                        bus.wr        <= (state == WRITE);
                        bus.xram_addr <= opaddr + {blk, 4'b0000} + {12'd0, idx};
                        if (state == WRITE)
                            bus.xram_data_out <= buf_q[byte_lsb +: 8] ^ ks[byte_lsb +: 8];
                    end else if (xfer_ack) begin
                        bus.stb <= 1'b0;
                        bus.wr  <= 1'b0;
                        idx     <= idx + 4'd1;
                        if (state == READ) begin
                            buf_q[byte_lsb +: 8] <= bus.xram_data_in;
                        end else if (last_byte && !abort_now) begin
                            uaes_ctr <= uaes_ctr + 128'd1;
                            blk      <= blk + 12'd1;
                        end
                    end
                    if (bus.stb && !bus.xram_ack && abort_req)
                        abort_pend <= 1'b1;
                    if (state_next == OPERATE) begin
                        bus.aes_start   <= 1'b1;
                        bus.aes_ctr_out <= uaes_ctr;
                    end
                end
                OPERATE: begin
                    if (state_next == WRITE)
                        ks <= bus.aes_out;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_xram_sequencer.sv
// -----------------------------------------------------------------------------
// tb_aes_xram_sequencer
//
// Directed bench for aes_xram_sequencer. An XRAM responder with a programmable
// ack delay and a cipher responder with a programmable done delay answer the
// DUT on the falling edge; the main initial block runs the directed steps and
// compares against hand-computed values. Define AES_SEQ_ABORT_EN to include
// the abort step.
// -----------------------------------------------------------------------------
module tb_aes_xram_sequencer;

    logic         clk        = 1'b0;
    logic         rst        = 1'b1;
    logic         cfg_start  = 1'b0;
    logic [15:0]  cfg_opaddr = '0;
    logic [15:0]  cfg_oplen  = '0;
    logic [127:0] cfg_ctr    = '0;
`ifdef AES_SEQ_ABORT_EN
    logic         cfg_abort  = 1'b0;
    logic         aborted;
`endif
    logic         busy;
    logic         done;
    logic [127:0] uaes_ctr;

    aes_xram_sequencer_if bus ();

    aes_xram_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_opaddr (cfg_opaddr),
        .cfg_oplen  (cfg_oplen),
        .cfg_ctr    (cfg_ctr),
`ifdef AES_SEQ_ABORT_EN
        .cfg_abort  (cfg_abort),
        .aborted    (aborted),
`endif
        .busy       (busy),
        .done       (done),
        .uaes_ctr   (uaes_ctr),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Responder state and logs.
    logic [7:0]   mem [0:65535];
    logic [15:0]  log_addr [0:511];
    logic         log_wr   [0:511];
    logic [7:0]   log_data [0:511];
    int           log_n    = 0;
    logic [127:0] ctr_log  [0:15];
    int           n_start  = 0;
    int           ack_delay = 0;
    int           aes_delay = 0;
    logic [127:0] ks_val    = '0;
    int           stab_err  = 0;
    int           gap_err   = 0;
    int           done_cnt  = 0;
    int           busy_cnt  = 0;

    logic         pend  = 1'b0;
    logic         acked = 1'b0;
    int           wcnt  = 0;
    logic [15:0]  r_addr;
    logic         r_wr;
    logic [7:0]   r_data;
    logic         apend = 1'b0;
    int           acnt  = 0;

    // XRAM responder: acks after ack_delay extra strobe cycles, checks that the
    // request is held stable and that the strobe drops after each ack.
    always @(negedge clk) begin
        bus.xram_ack = 1'b0;
        if (rst) begin
            pend  = 1'b0;
            acked = 1'b0;
        end else if (acked) begin
            if (bus.stb) gap_err++;
            acked = 1'b0;
        end else if (bus.stb) begin
            if (!pend) begin
                pend   = 1'b1;
                wcnt   = 0;
                r_addr = bus.xram_addr;
                r_wr   = bus.wr;
                r_data = bus.xram_data_out;
            end else if (bus.xram_addr !== r_addr || bus.wr !== r_wr ||
                         (r_wr && bus.xram_data_out !== r_data)) begin
                stab_err++;
            end
            if (wcnt >= ack_delay) begin
                bus.xram_ack = 1'b1;
                pend  = 1'b0;
                acked = 1'b1;
                if (r_wr) mem[r_addr] = r_data;
                else      bus.xram_data_in = mem[r_addr];
                if (log_n < 512) begin
                    log_addr[log_n] = r_addr;
                    log_wr[log_n]   = r_wr;
                    log_data[log_n] = r_wr ? r_data : mem[r_addr];
                end
                log_n++;
            end else begin
                wcnt++;
            end
        end
    end

    // Cipher responder: logs the counter of each start, answers after aes_delay.
    always @(negedge clk) begin
        bus.aes_done = 1'b0;
        if (rst) begin
            apend = 1'b0;
        end else begin
            if (bus.aes_start) begin
                if (n_start < 16) ctr_log[n_start] = bus.aes_ctr_out;
                n_start++;
                apend = 1'b1;
                acnt  = 0;
            end
            if (apend) begin
                if (acnt >= aes_delay) begin
                    bus.aes_done = 1'b1;
                    bus.aes_out  = ks_val;
                    apend = 1'b0;
                end else begin
                    acnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge after the start was sampled.
    task automatic start_op(input logic [15:0] a, input logic [15:0] l, input logic [127:0] c);
        cfg_opaddr = a;
        cfg_oplen  = l;
        cfg_ctr    = c;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start  = 1'b0;
    endtask

    // Waits (bounded) for done, then one more falling edge so counters settle.
    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, done === 1'b1, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        int l0, s0, d0, b0, n;
        logic bad;

        // ---- Reset state ----
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_stb", bus.stb, 1'b0);
        check("rst_wr", bus.wr, 1'b0);
        check("rst_aes_start", bus.aes_start, 1'b0);
        check("rst_addr", bus.xram_addr, 16'h0000);
        check("rst_wdata", bus.xram_data_out, 8'h00);
        check("rst_aes_ctr", bus.aes_ctr_out, 128'h0);
        check("rst_uaes_ctr", uaes_ctr, 128'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // ---- Zero length: one busy cycle with done, no strobes ----
        l0 = log_n;
        start_op(16'h1234, 16'h000F, 128'hCAFE_0000_0000_0000_0000_0000_0000_1234);
        check("zl_busy", busy, 1'b1);
        check("zl_done", done, 1'b1);
        @(negedge clk);
        check("zl_busy_after", busy, 1'b0);
        check("zl_done_after", done, 1'b0);
        check("zl_no_stb", log_n - l0, 0);
        check("zl_ctr", uaes_ctr, 128'hCAFE_0000_0000_0000_0000_0000_0000_1234);

        // ---- One block, zero-wait ack, same-cycle aes_done ----
        for (int i = 0; i < 16; i++) mem[16'h0100 + 16'(i)] = 8'(i);
        ack_delay = 0; aes_delay = 0;
        ks_val = {16{8'hFF}};
        l0 = log_n; s0 = n_start; d0 = done_cnt; b0 = busy_cnt;
        start_op(16'h0100, 16'h0010, 128'h5);
        wait_done("b1", 200);
        check("b1_xfers", log_n - l0, 32);
        bad = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (log_addr[l0 + i] !== 16'h0100 + 16'(i) || log_wr[l0 + i] !== 1'b0) bad = 1'b1;
            if (log_addr[l0 + 16 + i] !== 16'h0100 + 16'(i) || log_wr[l0 + 16 + i] !== 1'b1) bad = 1'b1;
        end
        check("b1_seq_bad", bad, 1'b0);
        for (int i = 0; i < 16; i++)
            check($sformatf("b1_wdata_%0d", i), mem[16'h0100 + 16'(i)], 8'hFF - 8'(i));
        check("b1_ctr_out", ctr_log[s0], 128'h5);
        check("b1_starts", n_start - s0, 1);
        check("b1_uaes_ctr", uaes_ctr, 128'h6);
        check("b1_done_cnt", done_cnt - d0, 1);
        check("b1_busy_cycles", busy_cnt - b0, 66);

        // ---- Two blocks across the 16-bit address wrap ----
        for (int i = 0; i < 32; i++) mem[16'hFFF8 + 16'(i)] = 8'(16'hFFF8 + 16'(i)) ^ 8'h3C;
        aes_delay = 2;
        ks_val = 128'h000102030405060708090A0B0C0D0E0F;
        l0 = log_n; s0 = n_start; d0 = done_cnt;
        start_op(16'hFFF8, 16'h0020, 128'hFF);
        wait_done("wrap", 400);
        check("wrap_xfers", log_n - l0, 64);
        check("wrap_rd0", log_addr[l0], 16'hFFF8);
        check("wrap_rd8", log_addr[l0 + 8], 16'h0000);
        check("wrap_wr0", log_addr[l0 + 16], 16'hFFF8);
        check("wrap_blk1_rd0", log_addr[l0 + 32], 16'h0008);
        check("wrap_blk1_wr15", log_addr[l0 + 63], 16'h0017);
        check("wrap_data_fff8", mem[16'hFFF8], 8'hC4);
        check("wrap_data_0000", mem[16'h0000], 8'h34);
        check("wrap_data_0017", mem[16'h0017], 8'h24);
        check("wrap_starts", n_start - s0, 2);
        check("wrap_ctr0", ctr_log[s0], 128'hFF);
        check("wrap_ctr1", ctr_log[s0 + 1], 128'h100);
        check("wrap_uaes_ctr", uaes_ctr, 128'h101);
        check("wrap_done_cnt", done_cnt - d0, 1);

        // ---- Counter wraps modulo 2^128 ----
        aes_delay = 0; ks_val = '0;
        s0 = n_start;
        start_op(16'h2000, 16'h0010, {128{1'b1}});
        wait_done("cwrap", 200);
        check("cwrap_ctr_out", ctr_log[s0], {128{1'b1}});
        check("cwrap_uaes_ctr", uaes_ctr, 128'h0);

        // ---- Slow acks, second start mid-operation is ignored ----
        ack_delay = 3;
        l0 = log_n; s0 = n_start; d0 = done_cnt; b0 = busy_cnt;
        start_op(16'h3000, 16'h0010, 128'h10);
        repeat (20) @(negedge clk);
        cfg_opaddr = 16'h5000; cfg_oplen = 16'h0030; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        wait_done("slow", 600);
        check("slow_xfers", log_n - l0, 32);
        check("slow_last_addr", log_addr[l0 + 31], 16'h300F);
        check("slow_starts", n_start - s0, 1);
        check("slow_uaes_ctr", uaes_ctr, 128'h11);
        check("slow_done_cnt", done_cnt - d0, 1);
        check("slow_busy_cycles", busy_cnt - b0, 162);
        check("stable_violations", stab_err, 0);
        check("gap_violations", gap_err, 0);

        // ---- Reset in the middle of WRITE ----
        start_op(16'h4000, 16'h0010, 128'h77);
        n = 0;
        while (!(bus.stb === 1'b1 && bus.wr === 1'b1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("mrst_reached_write", bus.stb === 1'b1 && bus.wr === 1'b1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_stb", bus.stb, 1'b0);
        check("mrst_wr", bus.wr, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_addr", bus.xram_addr, 16'h0000);
        check("mrst_uaes_ctr", uaes_ctr, 128'h0);
        rst = 1'b0;
        l0 = log_n; d0 = done_cnt;
        repeat (8) @(negedge clk);
        check("mrst_no_xfers", log_n - l0, 0);
        check("mrst_idle", busy, 1'b0);
        check("mrst_no_done", done_cnt - d0, 0);
        ack_delay = 0;
        start_op(16'h4100, 16'h0010, 128'h88);
        wait_done("recover", 200);
        check("recover_uaes_ctr", uaes_ctr, 128'h89);

`ifdef AES_SEQ_ABORT_EN
        // ---- Abort while waiting for the cipher on block 0 ----
        aes_delay = 5;
        l0 = log_n; d0 = done_cnt;
        start_op(16'h6000, 16'h0020, 128'h99);
        n = 0;
        while (bus.aes_start !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_operate", bus.aes_start, 1'b1);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_pulse", aborted, 1'b1);
        @(negedge clk);
        check("abort_pulse_end", aborted, 1'b0);
        repeat (8) @(negedge clk);
        n = 0;
        for (int i = l0; i < log_n; i++) if (log_wr[i] === 1'b1) n++;
        check("abort_no_writes", n, 0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_uaes_ctr", uaes_ctr, 128'h99);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
